// File: rtl/cpu_pkg.sv
// Shared types and exception codes for the commit-stage trap controller.
package cpu_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_TR   = 5'h0D;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] badvaddr;
  } exc_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } ctrl_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier;
  // plain 32-bit subtraction gives the wrap at address zero.
  function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic in_ds);
    return in_ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// Picks the oldest excepting way of the commit pair, builds its record
// and produces the write-back kill mask. Purely combinational.
module exc_prio_sel
  import cpu_pkg::*;
(
  input  logic             sel_en_i,
  input  logic [1:0]       way_valid_i,
  input  logic [1:0][4:0]  way_exc_code_i,
  input  logic [1:0][31:0] way_pc_i,
  input  logic [1:0]       way_in_ds_i,
  input  logic [1:0][31:0] way_badvaddr_i,
  input  logic [1:0]       way_eret_i,
  input  logic             int_pending_i,
  output logic             exc_o,
  output logic             eret_o,
  output exc_rec_t         rec_o,
  output logic [1:0]       kill_o
);

  logic       hit0;
  logic       hit1;
  logic       sel;
  logic [4:0] code_sel;

  // Oldest-first pick; a pending interrupt attaches to the first valid way.
  always_comb begin
    hit0     = way_valid_i[0] && (int_pending_i || (way_exc_code_i[0] != EXC_INT) || way_eret_i[0]);
    hit1     = way_valid_i[1] && (int_pending_i || (way_exc_code_i[1] != EXC_INT) || way_eret_i[1]);
    sel      = !hit0;
    code_sel = way_exc_code_i[sel];
    exc_o    = 1'b0;
    eret_o   = 1'b0;
    rec_o    = '0;
    kill_o   = 2'b00;
    if (sel_en_i && (hit0 || hit1)) begin
      kill_o = sel ? 2'b10 : 2'b11;
      if (int_pending_i) begin
        exc_o      = 1'b1;
        rec_o.code = EXC_INT;
      end else if (code_sel != EXC_INT) begin
        exc_o      = 1'b1;
        rec_o.code = code_sel;
      end else begin
        eret_o = 1'b1;
      end
      if (exc_o) begin
        rec_o.epc = calc_epc(way_pc_i[sel], way_in_ds_i[sel]);
        rec_o.bd  = way_in_ds_i[sel];
        if ((rec_o.code == EXC_ADEL) || (rec_o.code == EXC_ADES)) begin
          rec_o.badvaddr = way_badvaddr_i[sel];
        end
      end
    end
  end

endmodule

// File: rtl/trap_commit_ctrl.sv
// Commit-stage exception/ERET sequencer: hands one record to CP0, then
// drives a fixed-length flush and a single fetch redirect.
module trap_commit_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_en,
  input  logic [1:0]       way_valid,
  input  logic [1:0][4:0]  way_exc_code,
  input  logic [1:0][31:0] way_pc,
  input  logic [1:0]       way_in_ds,
  input  logic [1:0][31:0] way_badvaddr,
  input  logic [1:0]       way_eret,
  input  logic             int_pending,
  input  logic [31:0]      cp0_epc,
  input  logic             cp0_ack,
  output logic [1:0]       commit_kill,
  output logic             cp0_req,
  output logic [4:0]       cp0_exc_code,
  output logic [31:0]      cp0_epc_wr,
  output logic             cp0_bd,
  output logic [31:0]      cp0_badvaddr,
  output logic             cp0_eret,
  output logic             stall_o,
  output logic             flush_o,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  exc_rec_t         rec_q, rec_d;
  logic [31:0]      target_q, target_d;
  logic             eret_q, eret_d;

  logic             sel_en;
  logic             sel_exc;
  logic             sel_eret;
  exc_rec_t         sel_rec;
  logic [1:0]       sel_kill;
  logic             first_flush;

  assign sel_en = commit_en && (state_q == IDLE) && !reset;

  exc_prio_sel u_sel (
    .sel_en_i       (sel_en),
    .way_valid_i    (way_valid),
    .way_exc_code_i (way_exc_code),
    .way_pc_i       (way_pc),
    .way_in_ds_i    (way_in_ds),
    .way_badvaddr_i (way_badvaddr),
    .way_eret_i     (way_eret),
    .int_pending_i  (int_pending),
    .exc_o          (sel_exc),
    .eret_o         (sel_eret),
    .rec_o          (sel_rec),
    .kill_o         (sel_kill)
  );

  // Next-state logic: accept one event in IDLE, wait for ack, count the flush down.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rec_d    = rec_q;
    target_d = target_q;
    eret_d   = eret_q;
    case (state_q)
      IDLE: begin
        if (sel_exc) begin
          state_d = REQ;
          rec_d   = sel_rec;
          eret_d  = 1'b0;
        end else if (sel_eret) begin
          state_d  = FLUSH;
          target_d = cp0_epc;
          cnt_d    = CNT_INIT;
          eret_d   = 1'b1;
        end
      end
      REQ: begin
        if (cp0_ack) begin
          state_d  = FLUSH;
          target_d = EXC_VECTOR;
          cnt_d    = CNT_INIT;
          eret_d   = 1'b0;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and record registers; reset drops any in-flight record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rec_q    <= '0;
      target_q <= '0;
      eret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rec_q    <= rec_d;
      target_q <= target_d;
      eret_q   <= eret_d;
    end
  end

  assign first_flush    = (state_q == FLUSH) && (cnt_q == CNT_INIT);

  assign commit_kill    = sel_kill;
  assign cp0_req        = (state_q == REQ);
  assign cp0_exc_code   = rec_q.code;
  assign cp0_epc_wr     = rec_q.epc;
  assign cp0_bd         = rec_q.bd;
  assign cp0_badvaddr   = rec_q.badvaddr;
  assign cp0_eret       = first_flush && eret_q;
  assign stall_o        = (state_q != IDLE);
  assign flush_o        = (state_q == FLUSH);
  assign redirect_valid = first_flush;
  assign redirect_pc    = first_flush ? target_q : 32'h0;

endmodule
